// File: rtl/mdu_pkg.sv
// mdu_pkg: op encodings, FSM states and iteration count for the multiply/divide unit
package mdu_pkg;
  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT = 2'b01;
  localparam logic [1:0] OP_DIVU = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;
  localparam int ITER = 32;
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? -v : v;
  endfunction
endpackage

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-step multiply/divide with architectural HI/LO registers
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  state_t state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [1:0] op_q, op_d;
  logic sa_q, sa_d, sb_q, sb_d, done_q, done_d;
  logic [33:0] diff;
  logic [32:0] sum;
  logic [63:0] prod;
  logic [31:0] quo, rem;
  logic in_sgn, sgn, is_div;
  always_comb begin
    in_sgn = (op == OP_MULT) || (op == OP_DIV);
    sgn = (op_q == OP_MULT) || (op_q == OP_DIV);
    is_div = (op_q == OP_DIVU) || (op_q == OP_DIV);
    sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    diff = {1'b0, acc_q[63:31]} - {2'b0, b_q};
    prod = (sgn && (sa_q ^ sb_q)) ? -acc_q : acc_q;
    quo = (b_q == 32'd0) ? 32'hFFFF_FFFF : (sgn && (sa_q ^ sb_q)) ? -acc_q[31:0] : acc_q[31:0];
    rem = (sgn && sa_q) ? -acc_q[63:32] : acc_q[63:32];
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    b_d = b_q;
    op_d = op_q;
    sa_d = sa_q;
    sb_d = sb_q;
    hi_d = hi_q;
    lo_d = lo_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = {32'd0, mag(a, in_sgn)};
          b_d = mag(b, in_sgn);
          sa_d = in_sgn && a[31];
          sb_d = in_sgn && b[31];
          op_d = op;
          cnt_d = 5'd0;
          state_d = CALC;
        end else begin
          hi_d = mthi ? a : hi_q;
          lo_d = mtlo ? a : lo_q;
        end
      end
      CALC: begin
        acc_d = !is_div ? {sum, acc_q[31:1]} :
                (diff[33:32] != 2'b00) ? {acc_q[62:0], 1'b0} : {diff[31:0], acc_q[30:0], 1'b1};
        cnt_d = cnt_q + 5'd1;
        state_d = (cnt_q == 5'(ITER - 1)) ? FIX : CALC;
      end
      FIX: begin
        hi_d = is_div ? rem : prod[63:32];
        lo_d = is_div ? quo : prod[31:0];
        done_d = 1'b1;
        cnt_d = 5'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= 5'd0;
      acc_q <= 64'd0;
      b_q <= 32'd0;
      op_q <= 2'd0;
      sa_q <= 1'b0;
      sb_q <= 1'b0;
      hi_q <= 32'd0;
      lo_q <= 32'd0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      b_q <= b_d;
      op_q <= op_d;
      sa_q <= sa_d;
      sb_q <= sb_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      done_q <= done_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign hi = hi_q;
  assign lo = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed self-checking bench for mult_div_unit
module tb_mult_div_unit;
  logic clock = 1'b0;
  logic reset, start, mthi, mtlo, busy, done;
  logic [1:0] op;
  logic [31:0] a, b, hi, lo;
  int checks = 0;
  int errors = 0;
  always #5 clock = ~clock;
  mult_div_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] ehi, input logic [31:0] elo, input bit mv, input bit inject);
    int n;
    @(negedge clock);
    start = 1'b1; op = o; a = x; b = y; mthi = mv; mtlo = mv;
    @(negedge clock);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0; a = 32'd0; b = 32'd0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      if (inject && n == 5) begin start = 1'b1; mthi = 1'b1; mtlo = 1'b1; op = 2'b11; a = 32'hDEAD_BEEF; b = 32'd3; end
      if (inject && n == 6) begin start = 1'b0; mthi = 1'b0; mtlo = 1'b0; a = 32'd0; b = 32'd0; end
      @(negedge clock);
    end
    chk({tag, " busy_cycles"}, 64'(n), 64'd33);
    chk({tag, " done"}, 64'(done), 64'd1);
    chk({tag, " hi"}, 64'(hi), 64'(ehi));
    chk({tag, " lo"}, 64'(lo), 64'(elo));
    @(negedge clock);
    chk({tag, " done_drop"}, 64'(done), 64'd0);
    chk({tag, " idle"}, 64'(busy), 64'd0);
  endtask
  initial begin
    bit seen;
    reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; op = 2'd0; a = 32'd0; b = 32'd0;
    repeat (2) @(negedge clock);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst hi", 64'(hi), 64'd0);
    chk("rst lo", 64'(lo), 64'd0);
    reset = 1'b0;
    run("mult_neg3x7", 2'b01, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0);
    run("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
    run("div_neg7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
    run("divu_by0", 2'b10, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run("div_neg_by0", 2'b11, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run("div_min_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b0);
    run("divu_big", 2'b10, 32'hFFFF_FFFF, 32'd10, 32'd5, 32'h1999_9999, 1'b0, 1'b0);
    run("mult_negneg", 2'b01, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd0, 32'd6, 1'b0, 1'b0);
    run("start_wins", 2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 1'b1, 1'b0);
    run("mid_calc_ignored", 2'b00, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 1'b1);
    @(negedge clock);
    mthi = 1'b1; a = 32'h1234;
    @(negedge clock);
    mthi = 1'b0; a = 32'd0;
    chk("mthi hi", 64'(hi), 64'h1234);
    chk("mthi lo_kept", 64'(lo), 64'd15);
    chk("mthi no_done", 64'(done), 64'd0);
    mthi = 1'b1; mtlo = 1'b1; a = 32'hCAFE;
    @(negedge clock);
    mthi = 1'b0; mtlo = 1'b0; a = 32'd0;
    chk("mvboth hi", 64'(hi), 64'hCAFE);
    chk("mvboth lo", 64'(lo), 64'hCAFE);
    start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd6;
    @(negedge clock);
    start = 1'b0; a = 32'd0; b = 32'd0;
    repeat (9) @(negedge clock);
    chk("pre_rst busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst hi", 64'(hi), 64'd0);
    chk("midrst lo", 64'(lo), 64'd0);
    chk("midrst done", 64'(done), 64'd0);
    reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (done || busy) seen = 1'b1;
    end
    chk("midrst quiet", 64'(seen), 64'd0);
    chk("midrst lo_after", 64'(lo), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
